// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: accepts 8-bit words over valid/ready, shifts them MSB first into
// a history register and flags overlapping matches against a runtime-programmed pattern.
module pattern_scan_ctrl #(
  parameter int unsigned PAT_W = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [3:0]       cfg_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  input  logic             clr_cnt
);

  localparam logic [3:0]       LenMax = 4'(PAT_W);
  localparam logic [PAT_W-1:0] PatRst = PAT_W'(5'b10110);
  localparam logic [3:0]       LenRst = (PAT_W < 5) ? 4'(PAT_W) : 4'd5;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q, state_d;
  logic [7:0]         data_q, data_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [3:0]         fill_q, fill_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [3:0]         len_q, len_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               consume;
  logic               cfg_ok;
  logic               bit_in;
  logic [PAT_W:0]     hist_ext;
  logic [PAT_W-1:0]   hist_next;
  logic [3:0]         fill_next;
  logic [PAT_W-1:0]   len_mask;
  logic               match;

  // Datapath: next history, fill level and match decision for the bit consumed this cycle.
  always_comb begin
    in_ready  = (state_q == StIdle) || (bit_idx_q == 3'd0);
    busy      = (state_q == StShift);
    accept    = in_valid && in_ready;
    consume   = (state_q == StShift);
    cfg_ok    = cfg_we && (state_q == StIdle);
    bit_in    = data_q[bit_idx_q];
    hist_ext  = {hist_q, bit_in};
    hist_next = hist_ext[PAT_W-1:0];
    fill_next = (fill_q == LenMax) ? fill_q : fill_q + 4'd1;
    len_mask  = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
    match = consume && (len_q != 4'd0) && (fill_next >= len_q) &&
            (((hist_next ^ pat_q) & len_mask) == '0);
  end

  // Control FSM, configuration and counter next-state.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    hit_d     = match;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StShift;
          data_d    = in_data;
          bit_idx_d = 3'd7;
        end
      end
      StShift: begin
        bit_idx_d = bit_idx_q - 3'd1;
        if (bit_idx_q == 3'd0) begin
          if (accept) begin
            data_d    = in_data;
            bit_idx_d = 3'd7;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // History only advances in SHIFT; config writes only land in IDLE, so these never collide.
    if (consume) begin
      hist_d = hist_next;
      fill_d = fill_next;
    end
    if (cfg_ok) begin
      pat_d  = cfg_pat;
      len_d  = (cfg_len > LenMax) ? LenMax : cfg_len;
      hist_d = '0;
      fill_d = 4'd0;
      hit_d  = 1'b0;
    end

    if (clr_cnt) begin
      cnt_d = '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      data_q    <= '0;
      bit_idx_q <= 3'd0;
      hist_q    <= '0;
      fill_q    <= 4'd0;
      pat_q     <= PatRst;
      len_q     <= LenRst;
      hit_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      hit_q     <= hit_d;
      cnt_q     <= cnt_d;
    end
  end

  assign hit     = hit_q;
  assign hit_cnt = cnt_q;

endmodule
